// File: rtl/approx_err_pkg.sv
// Shared widths and the signed-difference / error-distance helper for the
// approximate-multiplier error monitor.
package approx_err_pkg;

  localparam int W  = 8;
  localparam int PW = 2 * W;
  localparam int DW = 2 * W + 1;

  // Returns {ed, diff}: diff = p - exact as a DW-bit signed value, ed = |diff|.
  function automatic logic [PW+DW-1:0] abs_diff(input logic [PW-1:0] p,
                                                input logic [PW-1:0] exact);
    logic [DW-1:0] diff;
    logic [PW-1:0] ed;
    diff = {1'b0, p} - {1'b0, exact};
    ed   = diff[DW-1] ? PW'(~diff + 1'b1) : PW'(diff);
    return {ed, diff};
  endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Two-stage front end: S1 captures operands and the exact product, S2 holds the
// signed difference, its magnitude and the nonzero flag.
module approx_err_calc #(
  parameter int W = approx_err_pkg::W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic [2*W-1:0]   p_i,
  output logic             s1_valid_o,
  output logic             s2_valid_o,
  output logic [W-1:0]     s2_a_o,
  output logic [W-1:0]     s2_b_o,
  output logic [2*W:0]     s2_diff_o,
  output logic [2*W-1:0]   s2_ed_o,
  output logic             s2_ne_o
);
  import approx_err_pkg::*;

  localparam int PW_L = 2 * W;
  localparam int DW_L = 2 * W + 1;

  logic            s1_valid_q, s2_valid_q, s2_ne_q;
  logic [W-1:0]    s1_a_q, s1_b_q, s2_a_q, s2_b_q;
  logic [PW_L-1:0] s1_p_q, s1_exact_q, s2_ed_q;
  logic [DW_L-1:0] s2_diff_q;

  logic [PW+DW-1:0] ad_c;
  logic [DW_L-1:0]  diff_c;
  logic [PW_L-1:0]  ed_c;

  // The helper works at the package width; narrower builds zero-extend and the
  // low bits of both results are still exact.
  assign ad_c   = abs_diff(PW'(s1_p_q), PW'(s1_exact_q));
  assign diff_c = ad_c[DW_L-1:0];
  assign ed_c   = ad_c[DW+PW_L-1:DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_p_q     <= '0;
      s1_exact_q <= '0;
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_diff_q  <= '0;
      s2_ed_q    <= '0;
      s2_ne_q    <= 1'b0;
    end else begin
      s1_valid_q <= valid_i & ~clear_i;
      s2_valid_q <= s1_valid_q & ~clear_i;
      if (valid_i) begin
        s1_a_q     <= a_i;
        s1_b_q     <= b_i;
        s1_p_q     <= p_i;
        s1_exact_q <= PW_L'(a_i) * PW_L'(b_i);
      end
      if (s1_valid_q) begin
        s2_a_q    <= s1_a_q;
        s2_b_q    <= s1_b_q;
        s2_diff_q <= diff_c;
        s2_ed_q   <= ed_c;
        s2_ne_q   <= (ed_c != '0);
      end
    end
  end

  assign s1_valid_o = s1_valid_q;
  assign s2_valid_o = s2_valid_q;
  assign s2_a_o     = s2_a_q;
  assign s2_b_o     = s2_b_q;
  assign s2_diff_o  = s2_diff_q;
  assign s2_ed_o    = s2_ed_q;
  assign s2_ne_o    = s2_ne_q;

endmodule

// File: rtl/approx_err_monitor.sv
// Error-statistics collector for the approximate multiplier: accumulates sample
// and error counts, error-distance sum, signed bias and the worst-case sample.
module approx_err_monitor #(
  parameter int W     = approx_err_pkg::W,
  parameter int CNT_W = 17,
  parameter int ACC_W = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [2*W-1:0]   in_p,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [ACC_W:0]   bias_sum,
  output logic [2*W-1:0]   ed_max,
  output logic [W-1:0]     max_a,
  output logic [W-1:0]     max_b,
  output logic             sat,
  output logic             idle
);
  import approx_err_pkg::*;

  localparam int PW_L = 2 * W;
  localparam int DW_L = 2 * W + 1;
  localparam int BW   = ACC_W + 1;

  logic            s1_valid, s2_valid, s2_ne;
  logic [W-1:0]    s2_a, s2_b;
  logic [DW_L-1:0] s2_diff;
  logic [PW_L-1:0] s2_ed;

  logic [CNT_W-1:0] cnt_q, cnt_d, err_q, err_d;
  logic [ACC_W-1:0] ed_sum_q, ed_sum_d;
  logic [BW-1:0]    bias_q, bias_d;
  logic [PW_L-1:0]  ed_max_q, ed_max_d;
  logic [W-1:0]     max_a_q, max_a_d, max_b_q, max_b_d;
  logic             sat_q, sat_d;

  approx_err_calc #(.W(W)) u_calc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear),
    .valid_i    (in_valid & ~sat_q),
    .a_i        (in_a),
    .b_i        (in_b),
    .p_i        (in_p),
    .s1_valid_o (s1_valid),
    .s2_valid_o (s2_valid),
    .s2_a_o     (s2_a),
    .s2_b_o     (s2_b),
    .s2_diff_o  (s2_diff),
    .s2_ed_o    (s2_ed),
    .s2_ne_o    (s2_ne)
  );

  always_comb begin
    cnt_d    = cnt_q;
    err_d    = err_q;
    ed_sum_d = ed_sum_q;
    bias_d   = bias_q;
    ed_max_d = ed_max_q;
    max_a_d  = max_a_q;
    max_b_d  = max_b_q;
    sat_d    = sat_q;
    if (clear) begin
      cnt_d    = '0;
      err_d    = '0;
      ed_sum_d = '0;
      bias_d   = '0;
      ed_max_d = '0;
      max_a_d  = '0;
      max_b_d  = '0;
      sat_d    = 1'b0;
    end else if (s2_valid && !sat_q) begin
      cnt_d    = cnt_q + 1'b1;
      err_d    = err_q + CNT_W'(s2_ne);
      ed_sum_d = ed_sum_q + ACC_W'(s2_ed);
      bias_d   = bias_q + BW'($signed(s2_diff));
      sat_d    = &cnt_d;
      // Strictly greater: on a tie the earlier sample keeps its operands.
      if (s2_ed > ed_max_q) begin
        ed_max_d = s2_ed;
        max_a_d  = s2_a;
        max_b_d  = s2_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      err_q    <= '0;
      ed_sum_q <= '0;
      bias_q   <= '0;
      ed_max_q <= '0;
      max_a_q  <= '0;
      max_b_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ed_sum_q <= ed_sum_d;
      bias_q   <= bias_d;
      ed_max_q <= ed_max_d;
      max_a_q  <= max_a_d;
      max_b_q  <= max_b_d;
      sat_q    <= sat_d;
    end
  end

  assign sample_cnt = cnt_q;
  assign err_cnt    = err_q;
  assign ed_sum     = ed_sum_q;
  assign bias_sum   = bias_q;
  assign ed_max     = ed_max_q;
  assign max_a      = max_a_q;
  assign max_b      = max_b_q;
  assign sat        = sat_q;
  assign idle       = ~(s1_valid | s2_valid);

endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Sequential error-statistics collector that sits directly downstream of the 8x8 approximate compressor-tree multiplier. Each cycle it accepts one operand pair and the approximate product that the multiplier produced for it, and recomputes the exact product internally. It accumulates the accuracy metrics used in the compressor analysis: sample count, error count, sum of error distance, signed error bias, and worst-case error with the operands that caused it. A host or testbench divides the results offline to get ER, MED and NMED.

## Interface
Parameters:
- W, 8, operand width; the product width is 2W.
- CNT_W, 17, width of the sample and error counters (covers an exhaustive 2^16 sweep).
- ACC_W, 33, width of the absolute error-distance accumulator; the signed bias accumulator is ACC_W+1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all statistics and in-flight samples.
- in_valid  in  1  in_a/in_b/in_p carry a sample this cycle.
- in_a  in  W  multiplicand.
- in_b  in  W  multiplier.
- in_p  in  2W  approximate product for (in_a, in_b).
- sample_cnt  out  CNT_W  number of samples accumulated.
- err_cnt  out  CNT_W  number of samples with in_p != in_a*in_b.
- ed_sum  out  ACC_W  sum of |exact - approx|.
- bias_sum  out  ACC_W+1  signed sum of (approx - exact), two's complement.
- ed_max  out  2W  largest single error distance.
- max_a, max_b  out  W  operands of the first sample that reached ed_max.
- sat  out  1  sample_cnt has reached all-ones; statistics are frozen.
- idle  out  1  no sample is in flight in the pipeline.

## Operation
- No backpressure: every in_valid cycle is accepted unless clear=1 or sat=1 in that cycle.
- Stage 1 (S1) registers a, b, p, exact = a*b (2W bits, unsigned) and a valid bit.
- Stage 2 (S2) registers diff = p - exact (signed, 2W+1 bits), ed = |diff|, ne = (ed != 0), and the operands.
- Stage 3 (ACC) runs when the S2 valid bit is set and sat=0:
  - sample_cnt += 1
  - err_cnt += ne
  - ed_sum += ed, zero-extended
  - bias_sum += diff, sign-extended
  - if ed > ed_max (strictly greater), load ed_max, max_a, max_b; ties keep the earlier sample.
- sat is set when the increment makes sample_cnt all-ones. While sat=1, new inputs are dropped and accumulation stops; only clear or reset releases it.
- ed_sum and bias_sum cannot overflow inside the CNT_W saturation limit at the default widths. Narrower builds wrap modulo 2^ACC_W.
- clear has priority over everything:
  - it zeroes all accumulators, sat and max_a/max_b;
  - it drops the S1/S2 valid bits (in-flight samples are discarded);
  - it ignores in_valid in the same cycle.

## Timing
- Reset (rst_n=0, asynchronous): every output is 0 except idle=1, and both pipeline valid bits are 0. Asserting reset mid-sweep discards all in-flight samples.
- Latency: a sample presented at edge N is captured by S1 at N, by S2 at N+1, and is visible on the outputs after edge N+2. Throughput is one sample per clock.
- idle = ~(S1.valid | S2.valid), combinational from the registers. Statistics are final when idle=1 and in_valid=0.
- Outputs are registered and stable between accumulation edges.
- clear at edge M gives zero outputs and idle=1 after M. A sample presented at M+1 is accepted normally.

## Structure
- Package approx_err_pkg holds W, the derived width constants (PW=2W, DW=2W+1), and function abs_diff returning {ed, diff}.
- Sub-module approx_err_calc: the S1+S2 pipeline (exact multiply, signed difference, absolute value, valid propagation). The top level holds the ACC stage, saturation and clear logic.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 -> all outputs 0, idle=1. Release -> no sample counted until in_valid is presented.
- Exact sample: a=15, b=15, p=225 -> after 3 edges: sample_cnt=1, err_cnt=0, ed_sum=0, bias_sum=0, ed_max=0, idle=1.
- Single error: a=255, b=255, p=65000 (exact 65025) -> err_cnt=1, ed_sum=25, bias_sum=-25, ed_max=25, max_a=255, max_b=255.
- Back-to-back tie: a=10, b=10, p=103, then a=20, b=5, p=97 -> sample_cnt=2, ed_sum=6, bias_sum=0, ed_max=3, max_a=10, max_b=10.
- Clear mid-flight: two valid samples with ed=4, clear on the next edge -> all outputs 0, idle=1; a following sample with ed=1 yields ed_sum=1.
- Saturation (CNT_W=3): 9 consecutive samples each with ed=1 -> sample_cnt=7, err_cnt=7, ed_sum=7, sat=1, and later samples are ignored.
